// File: rtl/char_gen_attr_pkg.sv
// Shared types and constants for the attributed text-mode character generator.
// Text RAM word layout: {blink, bg, fg, code}, code in the low bits.
package char_gen_pkg;

    typedef enum logic [1:0] {
        CUR_OFF   = 2'd0,
        CUR_BLOCK = 2'd1,
        CUR_UNDER = 2'd2,
        CUR_RSVD  = 2'd3
    } cursor_mode_e;

    // Edges from pixel sample to registered output.
    localparam int LATENCY = 3;

    function automatic int fg_lsb(input int code_w);
        return code_w;
    endfunction

    function automatic int bg_lsb(input int code_w, input int color_w);
        return code_w + color_w;
    endfunction

    function automatic int blink_pos(input int code_w, input int color_w);
        return code_w + 2 * color_w;
    endfunction

    function automatic int word_width(input int code_w, input int color_w);
        return code_w + 2 * color_w + 1;
    endfunction

endpackage

// File: rtl/char_gen_attr_if.sv
// CPU text-RAM write port and external font ROM port of the character generator.
// master = host/ROM side, slave = character generator.
interface char_gen_attr_if #(
    parameter int ADDR_W   = 12,
    parameter int WORD_W   = 17,
    parameter int FONT_A_W = 12,
    parameter int GLYPH_W  = 8
);
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data;
    logic [FONT_A_W-1:0] font_addr;
    logic [GLYPH_W-1:0]  font_data;

    modport master (
        output wr_en, wr_addr, wr_data, font_data,
        input  font_addr
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, font_data,
        output font_addr
    );
endinterface

// File: rtl/char_gen_attr_text_ram.sv
// Single-clock text/attribute RAM: one write port, one registered read port.
// Read-first on address collision; contents survive reset.
module text_ram_dp #(
    parameter int DEPTH  = 2400,
    parameter int ADDR_W = 12,
    parameter int WORD_W = 17
) (
    input  logic              pixel_clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge pixel_clock) begin
        if (wr_en && (int'(wr_addr) < DEPTH))
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/char_gen_attr.sv
// Attributed text-mode character generator: text RAM lookup, font ROM fetch,
// fg/bg colouring, character blink and block/underline cursor, 3-cycle pipeline.
module char_gen_attr
    import char_gen_pkg::*;
#(
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CODE_W       = 8,
    parameter int COLOR_W      = 4,
    parameter int BLINK_FRAMES = 30,
    parameter int X_W          = 11,
    parameter int Y_W          = 10,
    localparam int ADDR_W      = $clog2(COLS * ROWS),
    localparam int WORD_W      = word_width(CODE_W, COLOR_W),
    localparam int LINE_W      = $clog2(GLYPH_H),
    localparam int CCOL_W      = $clog2(COLS),
    localparam int CROW_W      = $clog2(ROWS)
) (
    input  logic               pixel_clock,
    input  logic               reset_n,
    input  logic [X_W-1:0]     pixel_x,
    input  logic [Y_W-1:0]     pixel_y,
    input  logic               video_active,
    input  logic [1:0]         sync_in,
    input  logic               frame_start,
    input  logic [CCOL_W-1:0]  cursor_col,
    input  logic [CROW_W-1:0]  cursor_row,
    input  logic [1:0]         cursor_mode,
    input  logic               cursor_blink_en,
    char_gen_attr_if.slave     bus,
    output logic               pixel_on,
    output logic [COLOR_W-1:0] color_out,
    output logic               active_out,
    output logic [1:0]         sync_out
);
    localparam int SUB_W     = $clog2(GLYPH_W);
    localparam int STAGES    = LATENCY - 1;
    localparam int BLK_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int FG_LSB    = fg_lsb(CODE_W);
    localparam int BG_LSB    = bg_lsb(CODE_W, COLOR_W);
    localparam int BLINK_BIT = blink_pos(CODE_W, COLOR_W);

    typedef struct packed {
        logic [SUB_W-1:0]  sub_px;
        logic [LINE_W-1:0] line;
        logic              blink_ph;
        logic              blk;
        logic              und;
    } s1_t;

    typedef struct packed {
        logic [SUB_W-1:0]   sub_px;
        logic               chr_blank;
        logic [COLOR_W-1:0] fg;
        logic [COLOR_W-1:0] bg;
        logic               blk;
        logic               und;
    } s2_t;

    typedef struct packed {
        logic               bit_on;
        logic [COLOR_W-1:0] fg;
        logic [COLOR_W-1:0] bg;
        logic               blk;
        logic               und;
    } s3_t;

    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_phase;
    logic                    rst_q;

    logic [X_W-1:0]          col0;
    logic [Y_W-1:0]          row0;
    logic [LINE_W-1:0]       line0;
    logic                    in_grid0;
    logic                    vld0;
    logic                    cur_hit0;
    cursor_mode_e            mode0;
    logic [ADDR_W-1:0]       rd_addr;
    logic [WORD_W-1:0]       ram_q;

    s1_t                     s1;
    s2_t                     s2;
    s3_t                     s3;
    logic [STAGES:0]         vld_pipe;
    logic [STAGES:0]         act_pipe;
    logic [STAGES:0][1:0]    sync_pipe;

    // S0: cell decode, RAM address and cursor match from the live inputs.
    assign col0     = pixel_x >> SUB_W;
    assign row0     = pixel_y >> LINE_W;
    assign line0    = pixel_y[LINE_W-1:0];
    assign in_grid0 = (int'(col0) < COLS) && (int'(row0) < ROWS);
    assign vld0     = video_active && in_grid0;
    assign rd_addr  = in_grid0 ? ADDR_W'(int'(row0) * COLS + int'(col0)) : '0;
    assign mode0    = cursor_mode_e'(cursor_mode);
    assign cur_hit0 = in_grid0 &&
                      (int'(col0) == int'(cursor_col)) &&
                      (int'(row0) == int'(cursor_row)) &&
                      (!cursor_blink_en || !blink_phase);

    text_ram_dp #(
        .DEPTH  (COLS * ROWS),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_text_ram (
        .pixel_clock (pixel_clock),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (ram_q)
    );

    assign bus.font_addr = {ram_q[CODE_W-1:0], s1.line};

    // First edge after reset release ignores frame_start.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            rst_q       <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (frame_start && !rst_q) begin
                if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            vld_pipe   <= '0;
            act_pipe   <= '0;
            sync_pipe  <= '0;
            pixel_on   <= 1'b0;
            color_out  <= '0;
            active_out <= 1'b0;
            sync_out   <= '0;
        end else begin
            s1.sub_px   <= pixel_x[SUB_W-1:0];
            s1.line     <= line0;
            s1.blink_ph <= blink_phase;
            s1.blk      <= cur_hit0 && (mode0 == CUR_BLOCK);
            s1.und      <= cur_hit0 && (mode0 == CUR_UNDER) && (line0 == LINE_W'(GLYPH_H - 1));

            s2.sub_px    <= s1.sub_px;
            s2.chr_blank <= ram_q[BLINK_BIT] & s1.blink_ph;
            s2.fg        <= ram_q[FG_LSB +: COLOR_W];
            s2.bg        <= ram_q[BG_LSB +: COLOR_W];
            s2.blk       <= s1.blk;
            s2.und       <= s1.und;

            // MSB of the glyph row is the leftmost pixel.
            s3.bit_on <= bus.font_data[SUB_W'(GLYPH_W - 1) - s2.sub_px] & ~s2.chr_blank;
            s3.fg     <= s2.fg;
            s3.bg     <= s2.bg;
            s3.blk    <= s2.blk;
            s3.und    <= s2.und;

            vld_pipe  <= {vld_pipe[STAGES-1:0], vld0};
            act_pipe  <= {act_pipe[STAGES-1:0], video_active};
            sync_pipe <= {sync_pipe[STAGES-1:0], sync_in};

            active_out <= act_pipe[STAGES];
            sync_out   <= sync_pipe[STAGES];
            if (!vld_pipe[STAGES]) begin
                pixel_on  <= 1'b0;
                color_out <= '0;
            end else if (s3.und) begin
                pixel_on  <= 1'b1;
                color_out <= s3.fg;
            end else if (s3.blk) begin
                pixel_on  <= ~s3.bit_on;
                color_out <= s3.bit_on ? s3.bg : s3.fg;
            end else begin
                pixel_on  <= s3.bit_on;
                color_out <= s3.bit_on ? s3.fg : s3.bg;
            end
        end
    end
endmodule

// File: tb/tb_char_gen_attr.sv
// Directed bench for char_gen_attr: vector table streamed through the pipeline
// plus hand-written blink and mid-frame reset sequences.
module tb_char_gen_attr;
    localparam int LAT = 3;

    logic        pixel_clock = 1'b0;
    logic        reset_n;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic        video_active;
    logic [1:0]  sync_in;
    logic        frame_start;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [1:0]  cursor_mode;
    logic        cursor_blink_en;
    logic        pixel_on;
    logic [3:0]  color_out;
    logic        active_out;
    logic [1:0]  sync_out;

    char_gen_attr_if #(.ADDR_W(12), .WORD_W(17), .FONT_A_W(12), .GLYPH_W(8)) bus ();

    char_gen_attr #(.BLINK_FRAMES(2)) dut (
        .pixel_clock     (pixel_clock),
        .reset_n         (reset_n),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .video_active    (video_active),
        .sync_in         (sync_in),
        .frame_start     (frame_start),
        .cursor_col      (cursor_col),
        .cursor_row      (cursor_row),
        .cursor_mode     (cursor_mode),
        .cursor_blink_en (cursor_blink_en),
        .bus             (bus),
        .pixel_on        (pixel_on),
        .color_out       (color_out),
        .active_out      (active_out),
        .sync_out        (sync_out)
    );

    always #5 pixel_clock = ~pixel_clock;

    // Font ROM model: line 0 is 8'h81, other lines {line, code[3:0]}.
    function automatic logic [7:0] font_fn(input logic [11:0] a);
        logic [7:0] code;
        logic [3:0] line;
        code = a[11:4];
        line = a[3:0];
        if (line == 4'd0) return 8'h81;
        return {line, code[3:0]};
    endfunction

    always @(posedge pixel_clock) bus.font_data <= font_fn(bus.font_addr);

    typedef struct {
        int       x;
        int       y;
        bit       act;
        bit [1:0] sync;
        bit       we;
        int       waddr;
        int       wdata;
        bit       on;
        int       col;
    } vec_t;

    vec_t vec [0:255];
    int   nvec = 0;
    int   checks = 0;
    int   failures = 0;

    function automatic int mk(input bit blink, input int bg, input int fg, input int code);
        return {15'd0, blink, bg[3:0], fg[3:0], code[7:0]};
    endfunction

    task automatic chk(input string name, input bit on, input int col, input bit act, input bit [1:0] sy);
        checks++;
        if (pixel_on !== on || color_out !== col[3:0] || active_out !== act || sync_out !== sy) begin
            failures++;
            $display("FAIL %s: got on=%0b color=%0d active=%0b sync=%0d, want on=%0b color=%0d active=%0b sync=%0d",
                     name, pixel_on, color_out, active_out, sync_out, on, col, act, sy);
        end
    endtask

    task automatic add(input int x, input int y, input bit act, input bit on, input int col);
        vec[nvec] = '{x: x, y: y, act: act, sync: 2'(nvec), we: 1'b0, waddr: 0, wdata: 0, on: on, col: col};
        nvec++;
    endtask

    task automatic add_w(input int x, input int y, input int waddr, input int wdata, input bit on, input int col);
        add(x, y, 1'b1, on, col);
        vec[nvec-1].we    = 1'b1;
        vec[nvec-1].waddr = waddr;
        vec[nvec-1].wdata = wdata;
    endtask

    // Eight pixels of one cell; pat gives expected pixel_on left to right.
    task automatic add_cell(input int cx, input int y, input bit [7:0] pat, input int fg, input int bg);
        for (int i = 0; i < 8; i++) begin
            bit p;
            p = pat[7-i];
            add(cx * 8 + i, y, 1'b1, p, p ? fg : bg);
        end
    endtask

    task automatic run_table(input int s);
        int n;
        n = nvec - s;
        for (int i = 0; i < n + LAT; i++) begin
            @(negedge pixel_clock);
            if (i < n) begin
                pixel_x      = 11'(vec[s+i].x);
                pixel_y      = 10'(vec[s+i].y);
                video_active = vec[s+i].act;
                sync_in      = vec[s+i].sync;
                bus.wr_en    = vec[s+i].we;
                bus.wr_addr  = 12'(vec[s+i].waddr);
                bus.wr_data  = 17'(vec[s+i].wdata);
            end else begin
                video_active = 1'b0;
                bus.wr_en    = 1'b0;
            end
            @(posedge pixel_clock);
            #1;
            if (i >= LAT)
                chk($sformatf("vec%0d", s + i - LAT), vec[s+i-LAT].on, vec[s+i-LAT].col,
                    vec[s+i-LAT].act, vec[s+i-LAT].sync);
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic wr(input int addr, input int data);
        @(negedge pixel_clock);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 12'(addr);
        bus.wr_data = 17'(data);
        @(negedge pixel_clock);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge pixel_clock);
        frame_start = 1'b1;
        @(negedge pixel_clock);
        frame_start = 1'b0;
    endtask

    initial begin
        int s;
        reset_n         = 1'b0;
        pixel_x         = '0;
        pixel_y         = '0;
        video_active    = 1'b1;
        sync_in         = 2'b11;
        frame_start     = 1'b0;
        cursor_col      = '0;
        cursor_row      = '0;
        cursor_mode     = 2'd0;
        cursor_blink_en = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        repeat (3) @(posedge pixel_clock);
        #1 chk("reset_state", 1'b0, 0, 1'b0, 2'd0);
        @(negedge pixel_clock);
        reset_n = 1'b1;

        wr(0, mk(0, 2, 9, 8'h41));
        wr(1, mk(0, 3, 5, 8'h42));
        wr(2, mk(1, 1, 7, 8'h44));
        wr(5, mk(0, 2, 9, 8'h41));
        wr(2399, mk(0, 6, 10, 8'h41));

        // Plain glyph colouring, blank pixels, last cell.
        s = nvec;
        add_cell(0, 0, 8'h81, 9, 2);
        add_cell(1, 0, 8'h81, 5, 3);
        add(640, 0, 1'b1, 1'b0, 0);
        add(0, 0, 1'b0, 1'b0, 0);
        add(0, 480, 1'b1, 1'b0, 0);
        add_cell(2, 0, 8'h81, 7, 1);
        add_cell(79, 464, 8'h81, 10, 6);
        run_table(s);

        // Block cursor on cell 0; cell 1 untouched.
        cursor_mode = 2'd1;
        s = nvec;
        add_cell(0, 0, 8'h7E, 9, 2);
        add_cell(1, 0, 8'h81, 5, 3);
        run_table(s);

        // Cursor column outside the grid.
        cursor_col = 7'd80;
        s = nvec;
        add(640, 0, 1'b1, 1'b0, 0);
        add_cell(0, 0, 8'h81, 9, 2);
        run_table(s);

        // Underline cursor only on the last glyph line; reserved mode is off.
        cursor_col  = 7'd0;
        cursor_mode = 2'd2;
        s = nvec;
        add_cell(0, 15, 8'hFF, 9, 2);
        add_cell(0, 14, 8'hE1, 9, 2);
        add_cell(1, 15, 8'hF2, 5, 3);
        run_table(s);
        cursor_mode = 2'd3;
        s = nvec;
        add_cell(0, 0, 8'h81, 9, 2);
        run_table(s);

        // Blink: one pulse keeps phase 0, second pulse flips it.
        cursor_mode = 2'd0;
        pulse_frame();
        s = nvec;
        add_cell(2, 0, 8'h81, 7, 1);
        run_table(s);
        pulse_frame();
        s = nvec;
        add_cell(2, 0, 8'h00, 7, 1);
        add_cell(0, 0, 8'h81, 9, 2);
        run_table(s);

        // Cursor with blink_en hidden during phase 1; block on a blinked cell.
        cursor_mode     = 2'd1;
        cursor_blink_en = 1'b1;
        s = nvec;
        add_cell(0, 0, 8'h81, 9, 2);
        run_table(s);
        cursor_blink_en = 1'b0;
        cursor_col      = 7'd2;
        s = nvec;
        add_cell(2, 0, 8'hFF, 7, 1);
        run_table(s);
        cursor_mode = 2'd0;
        cursor_col  = 7'd0;

        pulse_frame();
        pulse_frame();
        s = nvec;
        add_cell(2, 0, 8'h81, 7, 1);
        run_table(s);

        // Out-of-range write leaves RAM intact; same-cycle write is read-first.
        wr(2400, mk(0, 15, 15, 8'hFF));
        s = nvec;
        add_cell(0, 0, 8'h81, 9, 2);
        add_cell(79, 464, 8'h81, 10, 6);
        add_w(40, 0, 5, mk(0, 4, 6, 8'h41), 1'b1, 9);
        add(40, 0, 1'b1, 1'b1, 6);
        add(41, 0, 1'b1, 1'b0, 4);
        run_table(s);

        // Mid-frame reset with blink_phase=1 beforehand.
        pulse_frame();
        pulse_frame();
        s = nvec;
        add_cell(2, 0, 8'h00, 7, 1);
        run_table(s);
        @(negedge pixel_clock);
        pixel_x      = 11'd0;
        pixel_y      = 10'd0;
        video_active = 1'b1;
        sync_in      = 2'b11;
        repeat (4) @(posedge pixel_clock);
        #1 chk("pre_reset", 1'b1, 9, 1'b1, 2'b11);
        @(negedge pixel_clock);
        reset_n = 1'b0;
        @(posedge pixel_clock);
        #1 chk("reset_next_edge", 1'b0, 0, 1'b0, 2'd0);
        @(negedge pixel_clock);
        @(negedge pixel_clock);
        reset_n = 1'b1;
        pixel_x = 11'd16;
        for (int k = 0; k <= LAT; k++) begin
            @(posedge pixel_clock);
            #1;
            if (k < LAT) chk($sformatf("post_reset_%0d", k), 1'b0, 0, 1'b0, 2'd0);
            else         chk("post_reset_valid", 1'b1, 7, 1'b1, 2'b11);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
